// File: rtl/serial_in_parallel_load_32_bit.sv
// -----------------------------------------------------------------------------
// serial_in_parallel_load_32_bit
//
// Serial-to-parallel front end for a downstream PIPO register. Collects a
// framed serial bit stream, assembles DATA_WIDTH-bit words and presents each
// completed word on Parallel_Data_Out together with a one-cycle
// Load_Data_Signal_Out pulse. All state updates on the falling edge of Clk_In.
//
// Optional feature macro: SIPL_PARITY_CHECK_EN
//   When defined, every word is followed by one even-parity bit; a parity
//   mismatch drops the word and sets the sticky Parity_Error_Out.
//
// Parameters
//   DATA_WIDTH  word length in bits (>= 2)
//   MSB_FIRST   1: first serial bit lands in bit DATA_WIDTH-1; 0: in bit 0
//
// Ports
//   Clk_In                clock (falling-edge active)
//   Reset_In              asynchronous active-high reset
//   Enable_In             block enable; low freezes all state
//   Start_In              first bit of a frame (qualified by Serial_Valid_In)
//   Serial_Valid_In       Serial_Data_In is valid this cycle
//   Serial_Data_In        serial data bit
//   Clear_Error_In        clears the sticky error flags
//   Parallel_Data_Out     last completed word
//   Load_Data_Signal_Out  word-ready pulse for the downstream load input
//   Busy_Out              frame in progress or load pending
//   Frame_Error_Out       sticky: a frame was aborted by a new Start_In
//   Parity_Error_Out      sticky parity mismatch (SIPL_PARITY_CHECK_EN only)
// -----------------------------------------------------------------------------
module serial_in_parallel_load_32_bit #(
   parameter int DATA_WIDTH = 32,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Enable_In,
   input  logic                  Start_In,
   input  logic                  Serial_Valid_In,
   input  logic                  Serial_Data_In,
   input  logic                  Clear_Error_In,
   output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
   output logic                  Load_Data_Signal_Out,
   output logic                  Busy_Out,
   output logic                  Frame_Error_Out
`ifdef SIPL_PARITY_CHECK_EN
   ,
   output logic                  Parity_Error_Out
`endif
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_LOAD   = 2'd2;
`ifdef SIPL_PARITY_CHECK_EN
   localparam logic [1:0] ST_PARITY = 2'd3;
`endif

   logic [1:0]            state;
   logic [CNT_W-1:0]      bit_count;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] first_word;    // cleared register holding only the new bit
   logic [DATA_WIDTH-1:0] shifted_word;  // shift_reg with the new bit shifted in
   logic                  cap_start;
   logic                  cap_data;
   logic                  frame_abort;

   assign cap_start = Enable_In & Serial_Valid_In & Start_In;
   assign cap_data  = Enable_In & Serial_Valid_In & ~Start_In;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign first_word   = {{(DATA_WIDTH-1){1'b0}}, Serial_Data_In};
         assign shifted_word = {shift_reg[DATA_WIDTH-2:0], Serial_Data_In};
      end else begin : g_lsb_first
         assign first_word   = {Serial_Data_In, {(DATA_WIDTH-1){1'b0}}};
         assign shifted_word = {Serial_Data_In, shift_reg[DATA_WIDTH-1:1]};
      end
   endgenerate

   // A Start_In while a frame is being collected throws the partial frame away.
`ifdef SIPL_PARITY_CHECK_EN
   logic parity_bad;
   // Even parity over the word plus the parity bit being captured now.
   assign parity_bad  = (state == ST_PARITY) & cap_data & (^{shift_reg, Serial_Data_In});
   assign frame_abort = cap_start & ((state == ST_SHIFT) | (state == ST_PARITY));
`else
   assign frame_abort = cap_start & (state == ST_SHIFT);
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of statement order.
   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state             <= ST_IDLE;
         bit_count         <= '0;
         shift_reg         <= '0;
         Parallel_Data_Out <= '0;
      end else if (Enable_In) begin
         case (state)
            ST_IDLE: begin
               if (cap_start) begin
                  shift_reg <= first_word;
                  bit_count <= ONE_CNT;
                  state     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cap_start) begin
                  shift_reg <= first_word;
                  bit_count <= ONE_CNT;
               end else if (cap_data) begin
                  if (bit_count == LAST_CNT) begin
                     bit_count <= '0;
`ifdef SIPL_PARITY_CHECK_EN
                     shift_reg <= shifted_word;
                     state     <= ST_PARITY;
`else
                     Parallel_Data_Out <= shifted_word;
                     state             <= ST_LOAD;
`endif
                  end else begin
                     shift_reg <= shifted_word;
                     bit_count <= bit_count + ONE_CNT;
                  end
               end
            end
            ST_LOAD: begin
               // Back-to-back frames: a Start_In here begins the next word at once.
               if (cap_start) begin
                  shift_reg <= first_word;
                  bit_count <= ONE_CNT;
                  state     <= ST_SHIFT;
               end else begin
                  state <= ST_IDLE;
               end
            end
`ifdef SIPL_PARITY_CHECK_EN
            ST_PARITY: begin
               if (cap_start) begin
                  shift_reg <= first_word;
                  bit_count <= ONE_CNT;
                  state     <= ST_SHIFT;
               end else if (cap_data) begin
                  if (parity_bad) begin
                     state <= ST_IDLE;
                  end else begin
                     Parallel_Data_Out <= shift_reg;
                     state             <= ST_LOAD;
                  end
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error flags: a set on the same edge as a clear wins.
   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         Frame_Error_Out <= 1'b0;
      end else if (Enable_In) begin
         if (frame_abort) begin
            Frame_Error_Out <= 1'b1;
         end else if (Clear_Error_In) begin
            Frame_Error_Out <= 1'b0;
         end
      end
   end

`ifdef SIPL_PARITY_CHECK_EN
   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         Parity_Error_Out <= 1'b0;
      end else if (Enable_In) begin
         if (parity_bad) begin
            Parity_Error_Out <= 1'b1;
         end else if (Clear_Error_In) begin
            Parity_Error_Out <= 1'b0;
         end
      end
   end
`endif

   assign Load_Data_Signal_Out = (state == ST_LOAD);
   assign Busy_Out             = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_in_parallel_load_32_bit.sv
// -----------------------------------------------------------------------------
// tb_serial_in_parallel_load_32_bit
//
// Drives an MSB-first and an LSB-first instance with the same stimulus and
// compares every output after each falling edge against a frame-level model
// (list of received bits, assembled into a word arithmetically on completion).
// -----------------------------------------------------------------------------
module tb_serial_in_parallel_load_32_bit;

   localparam int W = 32;

   logic Clk_In, Reset_In, Enable_In, Start_In, Serial_Valid_In, Serial_Data_In, Clear_Error_In;
   logic [W-1:0] data_o [2];
   logic         load_o [2];
   logic         busy_o [2];
   logic         fe_o   [2];
`ifdef SIPL_PARITY_CHECK_EN
   logic         pe_o   [2];
`endif

   serial_in_parallel_load_32_bit #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .Clk_In(Clk_In), .Reset_In(Reset_In), .Enable_In(Enable_In), .Start_In(Start_In),
      .Serial_Valid_In(Serial_Valid_In), .Serial_Data_In(Serial_Data_In),
      .Clear_Error_In(Clear_Error_In), .Parallel_Data_Out(data_o[0]),
      .Load_Data_Signal_Out(load_o[0]), .Busy_Out(busy_o[0]), .Frame_Error_Out(fe_o[0])
`ifdef SIPL_PARITY_CHECK_EN
      , .Parity_Error_Out(pe_o[0])
`endif
   );

   serial_in_parallel_load_32_bit #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .Clk_In(Clk_In), .Reset_In(Reset_In), .Enable_In(Enable_In), .Start_In(Start_In),
      .Serial_Valid_In(Serial_Valid_In), .Serial_Data_In(Serial_Data_In),
      .Clear_Error_In(Clear_Error_In), .Parallel_Data_Out(data_o[1]),
      .Load_Data_Signal_Out(load_o[1]), .Busy_Out(busy_o[1]), .Frame_Error_Out(fe_o[1])
`ifdef SIPL_PARITY_CHECK_EN
      , .Parity_Error_Out(pe_o[1])
`endif
   );

   initial begin
      Clk_In = 1'b1;
      forever #5 Clk_In = ~Clk_In;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, index 0 = MSB-first instance, 1 = LSB-first instance.
   bit           m_frame [2];   // collecting data bits
   bit           m_load  [2];   // word delivered, load pulse showing
   bit           m_par   [2];   // waiting for the parity bit
   bit           m_fe    [2];
   bit           m_pe    [2];
   int           m_n     [2];
   bit           m_bits  [2][W];
   logic [W-1:0] m_word  [2];
   logic [W-1:0] m_out   [2];

   function automatic logic [W-1:0] assemble(input int m);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) begin
         if (m == 0) w = w | (W'(m_bits[m][i]) << (W - 1 - i));
         else        w = w | (W'(m_bits[m][i]) << i);
      end
      return w;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_frame[m] = 0; m_load[m] = 0; m_par[m] = 0; m_fe[m] = 0; m_pe[m] = 0;
         m_n[m] = 0; m_out[m] = '0; m_word[m] = '0;
      end
   endtask

   task automatic begin_frame(input int m);
      m_bits[m][0] = Serial_Data_In;
      m_n[m]       = 1;
      m_frame[m]   = 1;
   endtask

   task automatic model_step();
      bit cap, fe_set, pe_set;
      if (!Enable_In) return;
      cap = Serial_Valid_In;
      for (int m = 0; m < 2; m++) begin
         fe_set = 0;
         pe_set = 0;
         if (m_load[m]) begin
            m_load[m] = 0;
            if (cap && Start_In) begin_frame(m);
         end else if (m_par[m]) begin
            if (cap && Start_In) begin
               fe_set = 1; m_par[m] = 0; begin_frame(m);
            end else if (cap) begin
               m_par[m] = 0;
               if ((($countones(m_word[m]) + int'(Serial_Data_In)) % 2) == 0) begin
                  m_out[m] = m_word[m]; m_load[m] = 1;
               end else begin
                  pe_set = 1;
               end
            end
         end else if (m_frame[m]) begin
            if (cap && Start_In) begin
               fe_set = 1; begin_frame(m);
            end else if (cap) begin
               m_bits[m][m_n[m]] = Serial_Data_In;
               m_n[m]++;
               if (m_n[m] == W) begin
                  m_word[m]  = assemble(m);
                  m_n[m]     = 0;
                  m_frame[m] = 0;
`ifdef SIPL_PARITY_CHECK_EN
                  m_par[m]   = 1;
`else
                  m_out[m]   = m_word[m];
                  m_load[m]  = 1;
`endif
               end
            end
         end else if (cap && Start_In) begin
            begin_frame(m);
         end
         m_fe[m] = fe_set ? 1'b1 : (Clear_Error_In ? 1'b0 : m_fe[m]);
         m_pe[m] = pe_set ? 1'b1 : (Clear_Error_In ? 1'b0 : m_pe[m]);
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         check($sformatf("data%0d", m), data_o[m], m_out[m]);
         check($sformatf("load%0d", m), W'(load_o[m]), W'(m_load[m]));
         check($sformatf("busy%0d", m), W'(busy_o[m]), W'(m_frame[m] | m_load[m] | m_par[m]));
         check($sformatf("ferr%0d", m), W'(fe_o[m]), W'(m_fe[m]));
`ifdef SIPL_PARITY_CHECK_EN
         check($sformatf("perr%0d", m), W'(pe_o[m]), W'(m_pe[m]));
`endif
      end
   endtask

   // One clock: drive inputs, let the falling edge happen, compare #2 later.
   task automatic cycle(input bit en, input bit st, input bit vl, input bit dt, input bit clr);
      Enable_In = en; Start_In = st; Serial_Valid_In = vl; Serial_Data_In = dt; Clear_Error_In = clr;
      @(negedge Clk_In);
      if (Reset_In) model_reset();
      else          model_step();
      #2;
      compare_all();
   endtask

   task automatic send_bits(input logic [W-1:0] w, input bit lsb, input int vgaps, input int fgaps);
      int gpos = $urandom_range(1, W - 2);
      for (int i = 0; i < W; i++) begin
         int idx = lsb ? i : W - 1 - i;
         if (i == gpos) begin
            for (int g = 0; g < vgaps; g++) cycle(1, 1'($urandom), 0, 1'($urandom), 0);
            for (int g = 0; g < fgaps; g++) cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
         end
         cycle(1, i == 0, 1, w[idx], 0);
      end
   endtask

   // Full word; in the parity build it is followed by the correct parity bit.
   task automatic send_word(input logic [W-1:0] w, input bit lsb, input int vgaps, input int fgaps);
      send_bits(w, lsb, vgaps, fgaps);
`ifdef SIPL_PARITY_CHECK_EN
      cycle(1, 0, 1, ^w, 0);
`endif
   endtask

   initial begin
      logic [W-1:0] w;
      Reset_In = 1'b1;
      Enable_In = 0; Start_In = 0; Serial_Valid_In = 0; Serial_Data_In = 0; Clear_Error_In = 0;
      #1;
      model_reset();
      compare_all();
      cycle(1, 1, 1, 1, 0);
      cycle(1, 0, 1, 1, 0);
      Reset_In = 1'b0;
      cycle(1, 0, 0, 0, 0);

      // Basic MSB-first word.
      send_word(32'hA5A50F0F, 0, 0, 0);
      check("basic_word", data_o[0], 32'hA5A50F0F);
      check("basic_load", W'(load_o[0]), 32'd1);
      cycle(1, 0, 0, 0, 0);
      check("basic_load_end", W'(load_o[0]), 32'd0);

      // LSB-first order on the second instance.
      send_word(32'h00000001, 1, 0, 0);
      check("lsb_word", data_o[1], 32'h00000001);
      cycle(1, 0, 0, 0, 0);

      // Valid gaps, enable freeze mid-frame, and freeze during LOAD.
      send_word(32'h12345678, 0, 3, 2);
      check("gap_word", data_o[0], 32'h12345678);
      cycle(0, 0, 1, 1, 0);
      check("freeze_load_a", W'(load_o[0]), 32'd1);
      cycle(0, 1, 1, 0, 0);
      check("freeze_load_b", W'(load_o[0]), 32'd1);
      cycle(1, 0, 0, 0, 0);
      check("freeze_load_end", W'(load_o[0]), 32'd0);

      // Back-to-back words, second Start_In lands in the LOAD cycle.
      send_word(32'hFFFFFFFF, 0, 0, 0);
      check("b2b_first", data_o[0], 32'hFFFFFFFF);
      send_word(32'h00000000, 0, 0, 0);
      check("b2b_second", data_o[0], 32'h00000000);
      check("b2b_load", W'(load_o[0]), 32'd1);
      cycle(1, 0, 0, 0, 0);

      // Abort after 10 bits, then a complete word.
      for (int i = 0; i < 10; i++) cycle(1, i == 0, 1, 1'($urandom), 0);
      w = $urandom;
      send_word(w, 0, 0, 0);
      check("abort_ferr", W'(fe_o[0]), 32'd1);
      check("abort_word", data_o[0], w);
      cycle(1, 0, 0, 0, 1);
      check("clear_ferr", W'(fe_o[0]), 32'd0);

      // Reset between edges after 20 bits.
      for (int i = 0; i < 20; i++) cycle(1, i == 0, 1, 1'($urandom), 0);
      #3;
      Reset_In = 1'b1;
      #1;
      model_reset();
      compare_all();
      check("rst_busy", W'(busy_o[0]), 32'd0);
      cycle(1, 0, 1, 1, 0);
      Reset_In = 1'b0;
      for (int i = 0; i < 15; i++) cycle(1, 0, 1, 1'($urandom), 0);
      check("rst_no_load", W'(load_o[0]), 32'd0);

`ifdef SIPL_PARITY_CHECK_EN
      send_bits(32'h00000003, 0, 0, 0);
      cycle(1, 0, 1, 0, 0);
      check("par_good_word", data_o[0], 32'h00000003);
      check("par_good_load", W'(load_o[0]), 32'd1);
      cycle(1, 0, 0, 0, 0);
      send_bits(32'h00000003, 0, 0, 0);
      cycle(1, 0, 1, 1, 0);
      check("par_bad_load", W'(load_o[0]), 32'd0);
      check("par_bad_perr", W'(pe_o[0]), 32'd1);
      check("par_bad_word", data_o[0], 32'h00000003);
      cycle(1, 0, 0, 0, 1);
`endif

      // Randomized traffic: a mix of complete frames, aborts, gaps and freezes.
      for (int c = 0; c < 2000; c++) begin
         cycle(($urandom % 8) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
               1'($urandom), ($urandom % 50) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
